// File: rtl/mover_pkg.sv
// Shared types, status-byte layout and command-word builder for the DataMover sequencer.
package mover_pkg;

  // Run mode, sampled when a start is accepted.
  typedef enum logic [1:0] {
    MODE_NOP      = 2'b00,
    MODE_CAPTURE  = 2'b01,
    MODE_READBACK = 2'b10,
    MODE_BOTH     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_S2MM,
    ST_MM2S,
    ST_DONE
  } state_t;

  // DataMover status byte layout.
  localparam int STS_OKAY    = 7;
  localparam int STS_SLVERR  = 6;
  localparam int STS_DECERR  = 5;
  localparam int STS_INTERR  = 4;
  localparam int STS_TAG_MSB = 3;
  localparam int STS_TAG_LSB = 0;

  localparam logic CMD_TYPE_INCR = 1'b1;

  // Cycles the command/status interfaces are held in reset after reset_n releases.
  localparam int RST_HOLD_CYCLES = 16;

  // Widest command word supported (64-bit addresses); callers truncate to 40+ADDR_W.
  localparam int CMD_MAX_W = 104;
  typedef logic [CMD_MAX_W-1:0] cmd_max_t;

  // Assemble {4'b0, tag, addr, 8'b0, INCR, btt}; field positions follow addr_w/btt_w.
  function automatic cmd_max_t build_cmd(input logic [63:0] addr,
                                         input logic [3:0]  tag,
                                         input logic [31:0] btt,
                                         input int          addr_w = 32,
                                         input int          btt_w  = 23);
    cmd_max_t cmd;
    cmd_max_t btt_mask;
    btt_mask = (cmd_max_t'(1) << btt_w) - cmd_max_t'(1);
    cmd      = cmd_max_t'(btt) & btt_mask;
    cmd[23]  = CMD_TYPE_INCR;
    cmd      = cmd | (cmd_max_t'(addr) << 32) | (cmd_max_t'(tag) << (addr_w + 32));
    return cmd;
  endfunction

endpackage

// File: rtl/mover_channel.sv
// Per-direction issue/retire engine: command counters, ring offset wrap and status tag check.
module mover_channel
  import mover_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          BTT_W       = 23,
  parameter logic [31:0] BUF_BASE    = 32'h0000_0000,
  parameter logic [31:0] BUF_BYTES   = 32'h0001_0000,
  parameter logic [31:0] BURST_BYTES = 32'h0000_1000,
  parameter int          NUM_BURSTS  = 16,
  parameter int          MAX_OUT     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W+39:0] cmd_tdata,
  output logic              cmd_tvalid,
  input  logic              cmd_tready,
  input  logic [7:0]        sts_tdata,
  input  logic              sts_tvalid,
  output logic              phase_done,
  output logic              bad_sts
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0]  NUM_CNT  = CNT_W'(NUM_BURSTS);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] RING_A   = ADDR_W'(BUF_BYTES);

  typedef logic [ADDR_W+39:0] cmd_t;

  logic [CNT_W-1:0]  issued_q, retired_q, issued_nxt, retired_nxt, outstanding;
  logic [ADDR_W-1:0] offset_q;
  logic              accept, retire;

  assign outstanding = issued_q - retired_q;
  assign accept      = cmd_tvalid && cmd_tready;
  // A status with nothing outstanding is never retired; it only flags an error.
  assign retire      = sts_tvalid && (outstanding != '0);
  assign bad_sts     = sts_tvalid && ((outstanding == '0) || !sts_tdata[STS_OKAY] ||
                       (sts_tdata[STS_TAG_MSB:STS_TAG_LSB] != retired_q[3:0]));
  assign phase_done  = (retired_q == NUM_CNT);

  // tdata comes only from registers that move on accept, so it is stable while stalled.
  assign cmd_tdata = cmd_t'(build_cmd(64'(BASE_A + offset_q), issued_q[3:0],
                                      BURST_BYTES, ADDR_W, BTT_W));

  // Post-update counter values, used to register tvalid for the following cycle.
  // NOTE: combinational blocks assign every output first so no path can infer a latch.
  always_comb begin
    issued_nxt  = issued_q + CNT_W'(accept);
    retired_nxt = retired_q + CNT_W'(retire);
  end

  // Counters, ring offset and registered command valid.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q   <= '0;
      retired_q  <= '0;
      offset_q   <= '0;
      cmd_tvalid <= 1'b0;
    end else if (clear) begin
      issued_q   <= '0;
      retired_q  <= '0;
      offset_q   <= '0;
      cmd_tvalid <= 1'b0;
    end else begin
      issued_q   <= issued_nxt;
      retired_q  <= retired_nxt;
      if (accept) begin
        offset_q <= (offset_q + BURST_A == RING_A) ? '0 : offset_q + BURST_A;
      end
      cmd_tvalid <= enable && (issued_nxt < NUM_CNT) && ((issued_nxt - retired_nxt) < MAX_CNT);
    end
  end

endmodule

// File: rtl/mover_sequencer.sv
// DataMover command/status sequencer: capture into a ring buffer, optional readback, error tally.
// Optional feature: define MOVER_AUTO_RESTART_EN to self-restart RESTART_DELAY cycles into DONE.
module mover_sequencer
  import mover_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter int          BTT_W         = 23,
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_BYTES     = 32'h0001_0000,
  parameter logic [31:0] BURST_BYTES   = 32'h0000_1000,
  parameter int          NUM_BURSTS    = 16,
  parameter int          MAX_OUT       = 2,
  parameter int          RESTART_DELAY = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         err_count,
  output logic               m_axis_s2mm_cmdsts_aresetn,
  output logic [ADDR_W+39:0] s2mm_cmd_tdata,
  output logic               s2mm_cmd_tvalid,
  input  logic               s2mm_cmd_tready,
  input  logic [7:0]         s2mm_sts_tdata,
  input  logic               s2mm_sts_tvalid,
  output logic               s2mm_sts_tready,
  output logic               m_axis_mm2s_cmdsts_aresetn,
  output logic [ADDR_W+39:0] mm2s_cmd_tdata,
  output logic               mm2s_cmd_tvalid,
  input  logic               mm2s_cmd_tready,
  input  logic [7:0]         mm2s_sts_tdata,
  input  logic               mm2s_sts_tvalid,
  output logic               mm2s_sts_tready
);

  if (BURST_BYTES == 32'd0) begin : g_chk_burst_zero
    $error("BURST_BYTES must be nonzero");
  end else if ((BUF_BYTES % BURST_BYTES) != 32'd0) begin : g_chk_ring
    $error("BUF_BYTES must be a multiple of BURST_BYTES");
  end
  if (64'(BURST_BYTES) >= (64'd1 << BTT_W)) begin : g_chk_btt
    $error("BURST_BYTES must fit in BTT_W bits");
  end
  if (NUM_BURSTS < 1 || NUM_BURSTS > 65535) begin : g_chk_num
    $error("NUM_BURSTS out of range 1..65535");
  end
  if (MAX_OUT < 1 || MAX_OUT > 8) begin : g_chk_out
    $error("MAX_OUT out of range 1..8");
  end
  if (RESTART_DELAY < 0) begin : g_chk_delay
    $error("RESTART_DELAY must be non-negative");
  end

  state_t     state_q, state_d;
  mode_t      mode_q;
  logic [4:0] hold_q;
  logic [7:0] err_count_q;
  logic [8:0] err_sum;
  logic       cmdsts_ready, auto_start, start_acc;
  logic       s_en, m_en, s_done, m_done, s_bad, m_bad;

  assign cmdsts_ready               = (hold_q == 5'(RST_HOLD_CYCLES));
  assign m_axis_s2mm_cmdsts_aresetn = cmdsts_ready;
  assign m_axis_mm2s_cmdsts_aresetn = cmdsts_ready;
  assign s2mm_sts_tready            = 1'b1;
  assign mm2s_sts_tready            = 1'b1;
  assign err_count                  = err_count_q;
  assign err                        = (err_count_q != 8'd0);

  assign start_acc = (start || auto_start) && cmdsts_ready &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign s_en = (state_q == ST_S2MM) && mode_q[0];
  assign m_en = (state_q == ST_MM2S) && mode_q[1];

  // Hold the DataMover command/status interfaces in reset for a fixed count after reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           hold_q <= '0;
    else if (!cmdsts_ready) hold_q <= hold_q + 5'd1;
  end

`ifdef MOVER_AUTO_RESTART_EN
  localparam int RD_W = (RESTART_DELAY > 0) ? $clog2(RESTART_DELAY + 1) : 1;
  logic [RD_W-1:0] restart_q;

  // Countdown armed on entry to DONE; an external start reloads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                restart_q <= RD_W'(RESTART_DELAY);
    else if (state_q != ST_DONE || start_acc)    restart_q <= RD_W'(RESTART_DELAY);
    else if (restart_q != '0)                    restart_q <= restart_q - RD_W'(1);
  end

  assign auto_start = (state_q == ST_DONE) && (restart_q == '0);
`else
  assign auto_start = 1'b0;
`endif

  // State register, latched mode and saturating bad-status count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NOP;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc && start) mode_q <= mode_t'(mode);
      if (start_acc)          err_count_q <= '0;
      else if (busy)          err_count_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  // Phase sequencing; unselected phases fall through in one cycle.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == ST_S2MM) || (state_q == ST_MM2S);
    done    = (state_q == ST_DONE);
    err_sum = {1'b0, err_count_q} + 9'(s_bad) + 9'(m_bad);
    case (state_q)
      ST_IDLE, ST_DONE: if (start_acc) state_d = ST_S2MM;
      ST_S2MM: if (!mode_q[0] || s_done) state_d = mode_q[1] ? ST_MM2S : ST_DONE;
      ST_MM2S: if (!mode_q[1] || m_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  mover_channel #(
    .ADDR_W(ADDR_W), .BTT_W(BTT_W), .BUF_BASE(BUF_BASE), .BUF_BYTES(BUF_BYTES),
    .BURST_BYTES(BURST_BYTES), .NUM_BURSTS(NUM_BURSTS), .MAX_OUT(MAX_OUT)
  ) u_s2mm (
    .clk(clk), .reset_n(reset_n), .clear(start_acc), .enable(s_en),
    .cmd_tdata(s2mm_cmd_tdata), .cmd_tvalid(s2mm_cmd_tvalid), .cmd_tready(s2mm_cmd_tready),
    .sts_tdata(s2mm_sts_tdata), .sts_tvalid(s2mm_sts_tvalid),
    .phase_done(s_done), .bad_sts(s_bad)
  );

  mover_channel #(
    .ADDR_W(ADDR_W), .BTT_W(BTT_W), .BUF_BASE(BUF_BASE), .BUF_BYTES(BUF_BYTES),
    .BURST_BYTES(BURST_BYTES), .NUM_BURSTS(NUM_BURSTS), .MAX_OUT(MAX_OUT)
  ) u_mm2s (
    .clk(clk), .reset_n(reset_n), .clear(start_acc), .enable(m_en),
    .cmd_tdata(mm2s_cmd_tdata), .cmd_tvalid(mm2s_cmd_tvalid), .cmd_tready(mm2s_cmd_tready),
    .sts_tdata(mm2s_sts_tdata), .sts_tvalid(mm2s_sts_tvalid),
    .phase_done(m_done), .bad_sts(m_bad)
  );

endmodule

// File: tb/tb_mover_sequencer.sv
// Directed self-checking bench for mover_sequencer (5 bursts into a 2-burst ring).
module tb_mover_sequencer;

  localparam int          NUM   = 5;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] BURST = 32'h0000_1000;
  localparam logic [31:0] RING  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [1:0]  mode;
  logic        busy, done, err;
  logic [7:0]  err_count;
  logic        s_ar, m_ar;
  logic [71:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
  logic        s2mm_cmd_tvalid, s2mm_cmd_tready, mm2s_cmd_tvalid, mm2s_cmd_tready;
  logic [7:0]  s2mm_sts_tdata, mm2s_sts_tdata;
  logic        s2mm_sts_tvalid, s2mm_sts_tready, mm2s_sts_tvalid, mm2s_sts_tready;

  always #5 clk = ~clk;

  mover_sequencer #(
    .ADDR_W(32), .BTT_W(23), .BUF_BASE(BASE), .BUF_BYTES(RING), .BURST_BYTES(BURST),
    .NUM_BURSTS(NUM), .MAX_OUT(MAXO), .RESTART_DELAY(31)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
    .m_axis_s2mm_cmdsts_aresetn(s_ar),
    .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid),
    .s2mm_cmd_tready(s2mm_cmd_tready), .s2mm_sts_tdata(s2mm_sts_tdata),
    .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
    .m_axis_mm2s_cmdsts_aresetn(m_ar),
    .mm2s_cmd_tdata(mm2s_cmd_tdata), .mm2s_cmd_tvalid(mm2s_cmd_tvalid),
    .mm2s_cmd_tready(mm2s_cmd_tready), .mm2s_sts_tdata(mm2s_sts_tdata),
    .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
  } pend_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  pend_t       pend    [2][$];
  logic [7:0]  sts_ovr [2][$];
  logic [71:0] cmd_log [2][$];
  int          out_cnt [2];
  int          max_out [2];
  int          first_acc [2];
  int          last_ret  [2];
  bit          stray   [2];
  bit          hold    [2];
  logic [71:0] hold_data [2];
  int          tv_viol, unstable, hold_cycles, sts_delay, stall_from, stall_to;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] addr, input logic [3:0] tag);
    return {4'h0, tag, addr, 8'h00, 1'b1, 23'h001000};
  endfunction

  task automatic clear_agent();
    for (int c = 0; c < 2; c++) begin
      pend[c].delete(); sts_ovr[c].delete(); cmd_log[c].delete();
      out_cnt[c] = 0; max_out[c] = 0; first_acc[c] = -1; last_ret[c] = -1;
      stray[c] = 1'b0; hold[c] = 1'b0; hold_data[c] = '0;
    end
    tv_viol = 0; unstable = 0; hold_cycles = 0; stall_from = -1; stall_to = -1;
  endtask

  // One clock: observe at the falling edge, then drive ready/status for the next rising edge.
  task automatic step();
    logic [71:0] td  [2];
    logic        tv  [2];
    logic        rdy [2];
    logic        sv  [2];
    logic [7:0]  sd  [2];
    logic [7:0]  data;
    @(negedge clk);
    cyc++;
    td[0] = s2mm_cmd_tdata; tv[0] = s2mm_cmd_tvalid;
    td[1] = mm2s_cmd_tdata; tv[1] = mm2s_cmd_tvalid;
    for (int c = 0; c < 2; c++) begin
      if (tv[c] && out_cnt[c] >= MAXO) tv_viol++;
      if (hold[c] && td[c] !== hold_data[c]) unstable++;
      rdy[c] = !(c == 0 && cyc >= stall_from && cyc < stall_to);
      sv[c] = 1'b0; sd[c] = 8'h00;
      if (pend[c].size() > 0 && pend[c][0].due <= cyc) begin
        sv[c] = 1'b1; sd[c] = pend[c][0].data;
        void'(pend[c].pop_front());
        out_cnt[c]--; last_ret[c] = cyc;
      end else if (stray[c]) begin
        sv[c] = 1'b1; sd[c] = 8'h80; stray[c] = 1'b0;
      end
      if (tv[c] && rdy[c]) begin
        cmd_log[c].push_back(td[c]);
        if (first_acc[c] < 0) first_acc[c] = cyc;
        if (sts_ovr[c].size() > 0) data = sts_ovr[c].pop_front();
        else                       data = {4'h8, td[c][67:64]};
        pend[c].push_back('{due: cyc + 1 + sts_delay, data: data});
        out_cnt[c]++;
        if (out_cnt[c] > max_out[c]) max_out[c] = out_cnt[c];
      end
      if (tv[c] && !rdy[c]) hold_cycles++;
      hold[c] = tv[c] && !rdy[c]; hold_data[c] = td[c];
    end
    s2mm_cmd_tready = rdy[0]; s2mm_sts_tvalid = sv[0]; s2mm_sts_tdata = sd[0];
    mm2s_cmd_tready = rdy[1]; mm2s_sts_tvalid = sv[1]; mm2s_sts_tdata = sd[1];
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1; mode = m;
    step();
    start = 1'b0; mode = 2'b00;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      step(); k++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  // After reset_n release: interfaces stay in reset 16 cycles; a start during that is ignored.
  task automatic wait_hold(input string tag);
    for (int i = 1; i <= 15; i++) begin
      start = (i == 3); mode = 2'b01;
      step();
    end
    start = 1'b0;
    check({tag, "_aresetn_lo"}, {s_ar, m_ar}, 2'b00);
    check({tag, "_start_ignored"}, busy, 1'b0);
    step();
    check({tag, "_aresetn_hi"}, {s_ar, m_ar}, 2'b11);
  endtask

  task automatic check_cmds(input string tag, input int c);
    logic [71:0] got;
    check({tag, "_count"}, cmd_log[c].size(), NUM);
    for (int i = 0; i < NUM; i++) begin
      got = (i < cmd_log[c].size()) ? cmd_log[c][i] : '0;
      check($sformatf("%s_cmd%0d", tag, i), got,
            exp_cmd(BASE + ((i * BURST) % RING), 4'(i)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 2'b00; sts_delay = 0;
    s2mm_cmd_tready = 1'b1; mm2s_cmd_tready = 1'b1;
    s2mm_sts_tvalid = 1'b0; mm2s_sts_tvalid = 1'b0;
    s2mm_sts_tdata = '0; mm2s_sts_tdata = '0;
    clear_agent();
    repeat (3) step();
    check("rst_outs", {busy, done, err, s2mm_cmd_tvalid, mm2s_cmd_tvalid,
                       s2mm_sts_tready, mm2s_sts_tready, s_ar, m_ar}, 9'b000_00_11_00);
    check("rst_errcnt", err_count, 8'd0);
    reset_n = 1'b1;
    wait_hold("por");

    // Capture only, wrapping ring; a start mid-run must not change the run.
    clear_agent();
    do_start(2'b01);
    step(); step();
    start = 1'b1; mode = 2'b11;
    step();
    start = 1'b0; mode = 2'b00;
    run_until_done("cap", 300);
    check_cmds("cap", 0);
    check("cap_no_mm2s", cmd_log[1].size(), 0);
    check("cap_flags", {busy, err}, 2'b00);
    check("cap_limit", {tv_viol == 0, max_out[0] <= MAXO}, 2'b11);

`ifdef MOVER_AUTO_RESTART_EN
    begin
      int k = 0;
      while (s2mm_cmd_tvalid !== 1'b1 && k < 60) begin
        step(); k++;
      end
      check("restart_delay", (k >= 32 && k <= 34), 1'b1);
      run_until_done("auto", 300);
    end
`else
    repeat (40) step();
    check("done_holds", {done, busy}, 2'b10);
    check("no_restart", cmd_log[0].size(), NUM);
`endif

    // Capture then readback over the same region.
    clear_agent();
    do_start(2'b11);
    run_until_done("both", 600);
    check_cmds("both_s2mm", 0);
    check_cmds("both_mm2s", 1);
    check("mm2s_after_s2mm", (first_acc[1] > last_ret[0]), 1'b1);
    check("both_err", err, 1'b0);

    // Slow statuses: outstanding limit reached but never exceeded.
    clear_agent();
    sts_delay = 50;
    do_start(2'b01);
    run_until_done("slow", 1000);
    sts_delay = 0;
    check("slow_max_out", max_out[0], MAXO);
    check("slow_tv_viol", tv_viol, 0);
    check("slow_count", cmd_log[0].size(), NUM);

    // Backpressure: ten stalled cycles on the first command after the first accept.
    clear_agent();
    stall_from = cyc + 3; stall_to = cyc + 13;
    do_start(2'b01);
    run_until_done("bp", 300);
    check("bp_hold_cycles", hold_cycles, 10);
    check("bp_unstable", unstable, 0);
    check_cmds("bp", 0);

    // Bad statuses: SLVERR and a wrong tag; the run still completes.
    clear_agent();
    sts_ovr[0].push_back(8'h80); sts_ovr[0].push_back(8'h40); sts_ovr[0].push_back(8'h85);
    do_start(2'b01);
    run_until_done("errs", 300);
    check("errs_err", err, 1'b1);
    check("errs_count", err_count, 8'd2);
    check("errs_total", cmd_log[0].size(), NUM);
    clear_agent();
    do_start(2'b01);
    check("restart_clears", {done, busy, err, err_count}, {3'b010, 8'd0});
    run_until_done("errs2", 300);

    // No-op run: one busy cycle, then done.
    clear_agent();
    do_start(2'b00);
    check("nop_busy", {busy, done}, 2'b10);
    step();
    check("nop_done", {busy, done}, 2'b01);

    // Readback only, with a stray S2MM status that has no command outstanding.
    clear_agent();
    do_start(2'b10);
    step(); step();
    stray[0] = 1'b1;
    run_until_done("rb", 300);
    check_cmds("rb", 1);
    check("rb_no_s2mm", cmd_log[0].size(), 0);
    check("rb_stray_err", {err, err_count}, {1'b1, 8'd1});

    // Asynchronous reset in the middle of a capture.
    clear_agent();
    sts_delay = 50;
    do_start(2'b01);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("midrst_outs", {busy, done, s2mm_cmd_tvalid, s_ar, m_ar}, 5'b00000);
    clear_agent();
    sts_delay = 0;
    step();
    reset_n = 1'b1;
    wait_hold("midrst");
    clear_agent();
    do_start(2'b01);
    run_until_done("post", 300);
    check_cmds("post", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mover_sequencer.md
Name: mover_sequencer

Overview:
- Parametrised DataMover command/status sequencer; successor to the single-command S2MM/MM2S controller.
- On start, issues NUM_BURSTS S2MM commands of BURST_BYTES each into a ring buffer in memory, with up to MAX_OUT commands in flight.
- Optionally follows with an MM2S readback of the same region, then reports done and error counts.
- Sits between the capture FIFO / top-level control and the system block's DataMover command and status streams.

Parameters:
- ADDR_W, 32, DataMover address width; the command word is 40+ADDR_W bits wide.
- BTT_W, 23, bytes-to-transfer field width.
- BUF_BASE, 32'h0000_0000, ring buffer base byte address.
- BUF_BYTES, 32'h0001_0000, ring size in bytes; must be a multiple of BURST_BYTES (elaboration-time assertion).
- BURST_BYTES, 32'h0000_1000, bytes per command; must be nonzero and < 2**BTT_W.
- NUM_BURSTS, 16, commands per phase; range 1..65535.
- MAX_OUT, 2, maximum outstanding commands per phase; range 1..8.
- RESTART_DELAY, 31, idle cycles before auto-restart; used only with the optional feature.

Ports:
- clk  in  1  Clock.
- reset_n  in  1  Asynchronous active-low reset.
- start  in  1  One-cycle run request.
- mode  in  2  Sampled at start: 01 = capture only, 10 = readback only, 11 = capture then readback, 00 = no-op run.
- busy  out  1  High while running.
- done  out  1  Level; high from run completion until the next accepted start.
- err  out  1  Sticky error for the current run.
- err_count  out  8  Saturating count of bad statuses in the current run.
- m_axis_s2mm_cmdsts_aresetn  out  1  DataMover S2MM command/status reset.
- s2mm_cmd_tdata  out  40+ADDR_W  S2MM command word.
- s2mm_cmd_tvalid  out  1
- s2mm_cmd_tready  in  1
- s2mm_sts_tdata  in  8  S2MM status byte.
- s2mm_sts_tvalid  in  1
- s2mm_sts_tready  out  1
- m_axis_mm2s_cmdsts_aresetn  out  1  DataMover MM2S command/status reset.
- mm2s_cmd_tdata  out  40+ADDR_W  MM2S command word.
- mm2s_cmd_tvalid  out  1
- mm2s_cmd_tready  in  1
- mm2s_sts_tdata  in  8  MM2S status byte.
- mm2s_sts_tvalid  in  1
- mm2s_sts_tready  out  1

Behaviour:
- Reset values: busy, done, err, both cmd_tvalid = 0; err_count = 0; both sts_tready = 1; both cmdsts_aresetn = 0.
- cmdsts_aresetn stays 0 for 16 cycles after reset_n deasserts, then goes to 1. start is ignored until then.
- Command word layout: [BTT_W-1:0] = BURST_BYTES; [23] = 1 (INCR); [31:24] = 0; [ADDR_W+31:32] = address; [ADDR_W+35:ADDR_W+32] = tag; top 4 bits = 0.
- Tag = burst index[3:0].
- Address = BUF_BASE + offset. offset starts at 0 for each phase and advances by BURST_BYTES per accepted command. When offset + BURST_BYTES == BUF_BYTES, offset wraps to 0.
- States: IDLE -> S2MM -> MM2S -> DONE; phases not selected by mode are skipped. Mode 00 goes to DONE on the next cycle.
- start is accepted only in IDLE or DONE. On acceptance: done = 0, err = 0, err_count = 0, busy = 1, mode is latched. start while busy is ignored.
- Within a phase:
  - cmd_tvalid is registered, asserted while issued < NUM_BURSTS and (issued − retired) < MAX_OUT.
  - tdata is held stable while tvalid is high and not yet accepted.
  - A command is accepted on tvalid && tready.
  - A status is retired on each sts_tvalid beat.
  - The phase ends when retired == NUM_BURSTS. The next phase's first tvalid is asserted no earlier than the cycle after the last retire.
- Status check: status is bad if bit 7 (OKAY) == 0 or bits[3:0] != expected tag (statuses return in order). A bad status sets err and increments err_count, saturating at 255. The run continues.
- A command accept and a status retire in the same cycle both count; the outstanding count is unchanged.
- A status arriving with no command outstanding is counted as bad and not retired.
- DONE: busy = 0, done = 1; the machine holds until start.
- Asynchronous reset mid-run returns to reset values immediately.

Optional Feature:
- Macro MOVER_AUTO_RESTART_EN.
- Defined: in DONE, a counter loads RESTART_DELAY, decrements each cycle, and at 0 self-starts using the last latched mode. External start in DONE takes priority and reloads the counter.
- Undefined: no counter; DONE holds until external start.

Decomposition:
- Package mover_pkg holds:
  - the mode_t enum;
  - the state_t enum;
  - status bit positions (STS_OKAY = 7, STS_SLVERR = 6, STS_DECERR = 5, STS_INTERR = 4, STS_TAG = 3:0);
  - the CMD_TYPE_INCR constant;
  - the function build_cmd(addr, tag, btt).
- One natural sub-module, mover_channel: a per-direction issue/retire engine (counters, offset wrap, tag check). It is instantiated twice, once for S2MM and once for MM2S; the top-level FSM sequences the two.

Test Plan:
- Nominal capture: NUM_BURSTS = 4, BURST_BYTES = 0x1000, mode = 01, tready always 1, good statuses → 4 S2MM commands at addresses 0x0, 0x1000, 0x2000, 0x3000 with tags 0–3; no MM2S commands; done = 1; err = 0.
- Wrap: BUF_BYTES = 0x2000, NUM_BURSTS = 5, mode = 11 → S2MM addresses 0, 0x1000, 0, 0x1000, 0; MM2S phase repeats the same sequence after the fifth S2MM retire.
- Outstanding limit: MAX_OUT = 2, statuses delayed 50 cycles → never more than 2 unretired commands; tvalid deasserts until a status arrives.
- Backpressure: cmd_tready low 10 cycles mid-command → tdata stable throughout; exactly one accept per command.
- Errors: statuses 0x80, 0x40 (SLVERR), 0x85 (wrong tag) → err = 1, err_count = 2; run still completes with done = 1.
- Reset/start rules: start while busy → ignored; reset_n low mid-S2MM → busy = 0, cmd_tvalid = 0 immediately, aresetn low for 16 cycles after release. With MOVER_AUTO_RESTART_EN, RESTART_DELAY = 31 → next run's first command 33 ± 1 cycles after done rises.
